alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Front-end controller that sequences the board-level 6-bit ALU from one switch bank and three push-buttons. The operator loads operand A, then operand B, then the opcode, each from the shared switch bank. The sequencer then fires the ALU, waits out the ALU's registered latency, captures the result and holds it on the LEDs. It sits between the board I/O (switches, buttons, LEDs) and the ALU instance in the top level.

Parameters:
N_BITS, 6, width of switch bank, operands, opcode and ALU result
N_LEDS, 6, width of LED output
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button level is accepted (min 1; the top level overrides it to about 1_000_000 for hardware)
ALU_LATENCY, 1, clock cycles from o_start to a valid i_result (min 1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
i_sw  in  N_BITS  raw switch bank
i_btn_a  in  1  raw (bouncy, asynchronous) "load A" button
i_btn_b  in  1  raw "load B" button
i_btn_op  in  1  raw "load OP" button
i_result  in  N_BITS  ALU result
o_A  out  N_BITS  operand A to ALU
o_B  out  N_BITS  operand B to ALU
o_OP  out  N_BITS  opcode to ALU
o_start  out  1  one-cycle strobe: operands/opcode valid, ALU evaluates
o_led  out  N_LEDS  captured result
o_busy  out  1  high while in ST_EXEC
o_state  out  3  current FSM state encoding

Behaviour:
- Reset (reset=0, async):
  - o_A, o_B, o_OP, o_led = 0; o_start = 0; o_busy = 0.
  - FSM = ST_A; all synchronizers, debouncers and counters cleared.
  - Reset asserted mid-EXEC aborts the operation; o_led is not updated.
- Button path (per button):
  - 2-flop synchronizer.
  - Counter increments while the synchronized level differs from the stable level; it clears when they match.
  - When the counter is DEBOUNCE_CYCLES-1 and the levels still differ, the stable level takes the new value.
  - Press pulse = stable & ~stable_q, high for exactly one cycle.
  - A clean raw rise produces a pulse in the cycle following clock edge 2+DEBOUNCE_CYCLES after the rise.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Release produces no pulse.
- FSM states (encoding): ST_A=0, ST_B=1, ST_OP=2, ST_EXEC=3, ST_SHOW=4.
  - ST_A: press_a -> o_A <= i_sw, go ST_B.
  - ST_B: press_b -> o_B <= i_sw, go ST_OP.
  - ST_OP: press_op -> o_OP <= i_sw, o_start asserted next cycle, go ST_EXEC.
  - ST_EXEC:
    - o_busy = 1; o_start = 1 only in the first ST_EXEC cycle.
    - Latency counter loads ALU_LATENCY on entry and decrements each cycle.
    - In the cycle the counter reads 0: o_led <= i_result (truncate or zero-extend to N_LEDS), go ST_SHOW.
    - ST_EXEC therefore lasts ALU_LATENCY+1 cycles.
  - ST_SHOW: press_a -> o_A <= i_sw, go ST_B. This starts a new operation; o_led holds the old result until the next capture.
- Out-of-order presses (e.g. press_op in ST_A) are ignored; no register changes.
- Simultaneous pulses: only the pulse matching the current state acts; the others are dropped, not queued.
- All presses in ST_EXEC are ignored.
- o_A, o_B, o_OP hold their values between loads. They are never cleared except by reset.
- i_sw is sampled only on the accepting edge; switch changes at any other time have no effect.

Decomposition:
- Shared include alu_ctrl_defs.vh holds:
  - state encodings ST_A..ST_SHOW, with a 3-bit state width constant;
  - the opcode localparams ADD/SUB/AND/OR/XOR/SRA/SRL/NOR (6'b100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111), shared with the ALU and the bench.
- Sub-module btn_debouncer:
  - parameter DEBOUNCE_CYCLES;
  - ports clock, reset, i_btn, o_press;
  - instantiated three times.
- The FSM and latency counter stay in alu_op_sequencer.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with buttons toggling -> all outputs 0, o_state=0; release -> still 0, no o_start.
2. Full op: sw=5, press A; sw=3, press B; sw=6'b100000, press OP -> o_A=5, o_B=3, o_OP=ADD; o_start high exactly 1 cycle; o_busy for ALU_LATENCY+1 cycles; o_led=8; o_state=4.
3. Bounce: 2-cycle glitch on i_btn_a (DEBOUNCE_CYCLES=4) -> no load, o_state stays 0. Clean press -> pulse exactly at edge 2+4 after the rise, o_A loaded.
4. Ordering: in ST_A press OP then B -> no change. Press A and B in the same cycle in ST_A -> only A loads, state=1, B not loaded.
5. Ignore during exec: press A during ST_EXEC with ALU_LATENCY=3 -> no effect; o_led captures i_result at cycle 4 after entry.
6. Reset mid-exec: assert reset in 2nd ST_EXEC cycle -> o_led stays 0 (previous result cleared by reset), state=0. Restart with SUB 6,2 -> o_led=4.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer.
// FSM state encodings and the ALU opcode set.
package alu_op_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_A    = 3'd0,
        ST_B    = 3'd1,
        ST_OP   = 3'd2,
        ST_EXEC = 3'd3,
        ST_SHOW = 3'd4
    } state_t;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

endpackage

// File: rtl/alu_op_sequencer_btn_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce
// counter and single-cycle rising-edge press pulse.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync     <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync     <= {sync[0], i_btn};
            stable_q <= stable;
            if (sync[1] != stable) begin
                if (cnt == LAST) begin
                    stable <= sync[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign o_press = stable & ~stable_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B and opcode from the switch bank on button presses,
// fires the ALU, waits its latency and latches the result on LEDs.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int N_BITS          = 6,
    parameter int N_LEDS          = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ALU_LATENCY     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_sw,
    input  logic              i_btn_a,
    input  logic              i_btn_b,
    input  logic              i_btn_op,
    input  logic [N_BITS-1:0] i_result,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_BITS-1:0] o_OP,
    output logic              o_start,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam int LW = $clog2(ALU_LATENCY + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(ALU_LATENCY);

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] lat;
    logic          press_a;
    logic          press_b;
    logic          press_op;
    logic          ld_a;
    logic          ld_b;
    logic          ld_op;
    logic          cap;
    logic [N_LEDS-1:0] led_w;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clock(clock), .reset(reset), .i_btn(i_btn_a), .o_press(press_a)
    );
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clock(clock), .reset(reset), .i_btn(i_btn_b), .o_press(press_b)
    );
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
        .clock(clock), .reset(reset), .i_btn(i_btn_op), .o_press(press_op)
    );

    generate
        if (N_LEDS > N_BITS) begin : g_ext
            assign led_w = {{(N_LEDS-N_BITS){1'b0}}, i_result};
        end else begin : g_trunc
            assign led_w = i_result[N_LEDS-1:0];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_op    = 1'b0;
        cap      = 1'b0;
        case (state)
            ST_A, ST_SHOW: begin
                if (press_a) begin
                    ld_a     = 1'b1;
                    state_nx = ST_B;
                end
            end
            ST_B: begin
                if (press_b) begin
                    ld_b     = 1'b1;
                    state_nx = ST_OP;
                end
            end
            ST_OP: begin
                if (press_op) begin
                    ld_op    = 1'b1;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (lat == '0) begin
                    cap      = 1'b1;
                    state_nx = ST_SHOW;
                end
            end
            default: state_nx = ST_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_A;
            lat   <= '0;
            o_A   <= '0;
            o_B   <= '0;
            o_OP  <= '0;
            o_led <= '0;
        end else begin
            state <= state_nx;
            if (ld_a)  o_A   <= i_sw;
            if (ld_b)  o_B   <= i_sw;
            if (ld_op) o_OP  <= i_sw;
            if (cap)   o_led <= led_w;
            // counter rests at zero outside EXEC
            if (ld_op)
                lat <= LAT_INIT;
            else if (lat != '0)
                lat <= lat - 1'b1;
        end
    end

    assign o_busy  = (state == ST_EXEC);
    assign o_start = (state == ST_EXEC) && (lat == LAT_INIT);
    assign o_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a latency-3 ALU model.
// Expected LED values are queued at opcode press, checked at capture.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int NB = 6;
    localparam int DB = 4;
    localparam int L  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] i_sw = '0;
    logic          i_btn_a = 1'b0;
    logic          i_btn_b = 1'b0;
    logic          i_btn_op = 1'b0;
    logic [NB-1:0] i_result;
    logic [NB-1:0] o_A, o_B, o_OP;
    logic          o_start, o_busy;
    logic [NB-1:0] o_led;
    logic [2:0]    o_state;

    int n_checks = 0;
    int n_err = 0;
    int start_cnt = 0;
    int busy_cnt = 0;
    logic [2:0] prev_state = 3'd0;
    logic [NB-1:0] sb[$];

    logic [NB-1:0] pd [L];
    logic          pv [L];

    alu_op_sequencer #(
        .N_BITS(NB), .N_LEDS(NB),
        .DEBOUNCE_CYCLES(DB), .ALU_LATENCY(L)
    ) dut (
        .clock(clock), .reset(reset), .i_sw(i_sw),
        .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
        .i_result(i_result), .o_A(o_A), .o_B(o_B), .o_OP(o_OP),
        .o_start(o_start), .o_led(o_led), .o_busy(o_busy),
        .o_state(o_state)
    );

    always #5 clock = ~clock;

    function automatic logic [NB-1:0] alu_f(
        input logic [NB-1:0] op, input logic [NB-1:0] a,
        input logic [NB-1:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SRA:     return NB'($signed(a) >>> b);
            SRL:     return a >> b;
            NOR:     return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // ALU model: result valid exactly L cycles after o_start
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= o_start;
            pd[0] <= alu_f(o_OP, o_A, o_B);
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign i_result = pv[L-1] ? pd[L-1] : 6'h15;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (o_start) start_cnt++;
        if (o_busy) busy_cnt++;
        if (prev_state == 3'd3 && o_state == 3'd4) begin
            if (sb.size() == 0)
                check("sb_underflow", sb.size(), 1);
            else
                check("led", o_led, sb.pop_front());
        end
        prev_state = o_state;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int which, input logic [NB-1:0] sw);
        i_sw = sw;
        case (which)
            0: i_btn_a = 1'b1;
            1: i_btn_b = 1'b1;
            default: i_btn_op = 1'b1;
        endcase
        cyc(12);
        i_btn_a = 1'b0;
        i_btn_b = 1'b0;
        i_btn_op = 1'b0;
        cyc(8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A"}, o_A, 0);
        check({tag, "_B"}, o_B, 0);
        check({tag, "_OP"}, o_OP, 0);
        check({tag, "_led"}, o_led, 0);
        check({tag, "_start"}, o_start, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_state"}, o_state, 0);
    endtask

    initial begin
        // reset with buttons toggling
        repeat (3) begin
            @(negedge clock);
            i_btn_a = ~i_btn_a;
            i_btn_b = ~i_btn_b;
            i_btn_op = ~i_btn_op;
        end
        check_zero("rst");
        i_btn_a = 0; i_btn_b = 0; i_btn_op = 0;
        reset = 1'b1;
        cyc(10);
        check_zero("post_rst");
        check("post_rst_nostart", start_cnt, 0);

        // short glitch is filtered
        i_btn_a = 1'b1;
        cyc(2);
        i_btn_a = 1'b0;
        cyc(10);
        check("glitch_state", o_state, 0);
        check("glitch_A", o_A, 0);

        // clean press: pulse after edge 2+DB, load on the next edge
        i_sw = 6'd9;
        i_btn_a = 1'b1;
        cyc(2 + DB);
        check("edge6_state", o_state, 0);
        check("edge6_A", o_A, 0);
        cyc(1);
        check("edge7_state", o_state, 1);
        check("edge7_A", o_A, 9);
        i_btn_a = 1'b0;
        cyc(10);

        // out-of-order presses in ST_B
        press(2, 6'h11);
        check("stB_op_state", o_state, 1);
        check("stB_op_OP", o_OP, 0);
        press(0, 6'h22);
        check("stB_a_state", o_state, 1);
        check("stB_a_A", o_A, 9);

        reset = 1'b0;
        @(negedge clock);
        check_zero("rst2");
        reset = 1'b1;
        cyc(2);

        // out-of-order presses in ST_A
        press(2, 6'h01);
        check("stA_op_state", o_state, 0);
        check("stA_op_OP", o_OP, 0);
        press(1, 6'h02);
        check("stA_b_state", o_state, 0);
        check("stA_b_B", o_B, 0);

        // A and B together: only A acts
        i_sw = 6'd5;
        i_btn_a = 1'b1;
        i_btn_b = 1'b1;
        cyc(12);
        i_btn_a = 1'b0;
        i_btn_b = 1'b0;
        cyc(8);
        check("simul_state", o_state, 1);
        check("simul_A", o_A, 5);
        check("simul_B", o_B, 0);

        // full ADD 5+3
        press(1, 6'd3);
        check("add_state_op", o_state, 2);
        check("add_B", o_B, 3);
        start_cnt = 0;
        busy_cnt = 0;
        sb.push_back(alu_f(ADD, 6'd5, 6'd3));
        press(2, ADD);
        check("add_OP", o_OP, ADD);
        check("add_start", start_cnt, 1);
        check("add_busy", busy_cnt, L + 1);
        check("add_state", o_state, 4);
        check("add_led", o_led, 8);

        // new op from SHOW; A press during EXEC is ignored
        press(0, 6'd7);
        check("show_a_state", o_state, 1);
        check("show_led_hold", o_led, 8);
        check("show_a_A", o_A, 7);
        press(1, 6'd9);
        start_cnt = 0;
        busy_cnt = 0;
        sb.push_back(alu_f(XOR, 6'd7, 6'd9));
        i_sw = XOR;
        i_btn_op = 1'b1;
        cyc(3);
        i_btn_a = 1'b1;
        cyc(12);
        i_btn_a = 1'b0;
        i_btn_op = 1'b0;
        cyc(8);
        check("xor_A", o_A, 7);
        check("xor_OP", o_OP, XOR);
        check("xor_state", o_state, 4);
        check("xor_start", start_cnt, 1);
        check("xor_busy", busy_cnt, L + 1);
        check("xor_led", o_led, 14);

        // reset in the second EXEC cycle aborts
        press(0, 6'd6);
        press(1, 6'd2);
        i_sw = SUB;
        i_btn_op = 1'b1;
        cyc(2 + DB + 2);
        check("abort_busy", o_busy, 1);
        check("abort_in_exec", o_state, 3);
        reset = 1'b0;
        #1;
        check_zero("abort");
        i_btn_op = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cyc(3);

        // restart with SUB 6-2
        press(0, 6'd6);
        press(1, 6'd2);
        start_cnt = 0;
        sb.push_back(alu_f(SUB, 6'd6, 6'd2));
        press(2, SUB);
        check("sub_state", o_state, 4);
        check("sub_start", start_cnt, 1);
        check("sub_led", o_led, 4);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
